// File: rtl/wheel_ctrl_pkg.sv
// Shared types and constants for the wheel setpoint path.
// Sign-magnitude Q8.8 values with the sign in the top bit.
package wheel_ctrl_pkg;

  localparam int N_WIDTH = 17;
  localparam int Q_WIDTH = 8;
  localparam int SGN_BIT = N_WIDTH - 1;
  localparam int MAG_W   = N_WIDTH - 1;
  localparam int MAG_MSB = MAG_W - 1;

  localparam logic [N_WIDTH-1:0] ZERO_W = '0;
  localparam logic [N_WIDTH-1:0] NEG_ZERO_W = {1'b1, {MAG_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RAMP,
    ST_BRAKE
  } ramp_state_t;

  function automatic logic [N_WIDTH-1:0] norm_w(
    input logic [N_WIDTH-1:0] v
  );
    return (v[MAG_MSB:0] == '0) ? ZERO_W : v;
  endfunction

endpackage

// File: rtl/wheel_ramp_step.sv
// One slew-limited step of the output setpoint toward the
// effective target; a reversal always decays through +0.
import wheel_ctrl_pkg::*;

module wheel_ramp_step (
  input  logic [N_WIDTH-1:0] i_out,
  input  logic [N_WIDTH-1:0] i_eff,
  input  logic [MAG_W-1:0]   i_max_step,
  output logic [N_WIDTH-1:0] o_out_nxt,
  output ramp_state_t        o_state_nxt
);

  logic [MAG_W-1:0] w_mo;
  logic [MAG_W-1:0] w_me;
  logic             w_same;
  logic [MAG_W-1:0] w_mag;
  logic             w_sgn;

  assign w_mo = i_out[MAG_MSB:0];
  assign w_me = i_eff[MAG_MSB:0];
  assign w_same = (i_out[SGN_BIT] == i_eff[SGN_BIT])
                | (w_mo == '0);

  always_comb begin
    w_mag = '0;
    w_sgn = 1'b0;
    if (w_same) begin
      w_sgn = i_eff[SGN_BIT];
      if (w_me >= w_mo)
        w_mag = (w_me - w_mo <= i_max_step)
              ? w_me : w_mo + i_max_step;
      else
        w_mag = (w_mo - w_me <= i_max_step)
              ? w_me : w_mo - i_max_step;
    end else begin
      w_sgn = i_out[SGN_BIT];
      w_mag = (w_mo <= i_max_step)
            ? '0 : w_mo - i_max_step;
    end
  end

  assign o_out_nxt = (w_mag == '0) ? ZERO_W : {w_sgn, w_mag};

  always_comb begin
    o_state_nxt = ST_RAMP;
    if (o_out_nxt == i_eff)
      o_state_nxt = ST_HOLD;
    else if ((w_mag != '0) && (w_sgn != i_eff[SGN_BIT]))
      o_state_nxt = ST_BRAKE;
  end

endmodule

// File: rtl/wheel_setpoint_ramp.sv
// Command buffer, tick-driven slew limiter and watchdog
// feeding the wheel controller's target-omega input.
import wheel_ctrl_pkg::*;

module wheel_setpoint_ramp #(
  parameter logic [MAG_W-1:0] MAX_STEP   = 16'h0080,
  parameter int               WDOG_TICKS = 6
) (
  input  logic               WHEEL_SETPOINT_RAMP_CLOCK,
  input  logic               WHEEL_SETPOINT_RAMP_RESET_InLow,
  input  logic               WHEEL_SETPOINT_RAMP_TICK167ms_In,
  input  logic [N_WIDTH-1:0] WHEEL_SETPOINT_RAMP_CMD_InBus,
  input  logic               WHEEL_SETPOINT_RAMP_CMD_VALID_In,
  output logic               WHEEL_SETPOINT_RAMP_CMD_READY_Out,
  output logic [N_WIDTH-1:0] WHEEL_SETPOINT_RAMP_TARGETW_OutBus,
  output logic               WHEEL_SETPOINT_RAMP_AT_TARGET_Out,
  output logic               WHEEL_SETPOINT_RAMP_TIMEOUT_Out
);

  localparam int WD_W = $clog2(WDOG_TICKS + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_TICKS);

  logic               w_clk;
  logic               w_rst_n;
  logic               w_tick;
  logic               w_acc;
  logic               w_expire;
  logic [WD_W-1:0]    w_wd_inc;
  logic [N_WIDTH-1:0] w_eff;
  logic [N_WIDTH-1:0] w_out_nxt;
  ramp_state_t        w_st_nxt;

  logic               r_live;
  logic [N_WIDTH-1:0] r_pend;
  logic               r_pend_v;
  logic [N_WIDTH-1:0] r_tgt;
  logic [N_WIDTH-1:0] r_out;
  logic [WD_W-1:0]    r_wd;
  logic               r_at;
  logic               r_to;
  ramp_state_t        r_state;

  assign w_clk   = WHEEL_SETPOINT_RAMP_CLOCK;
  assign w_rst_n = WHEEL_SETPOINT_RAMP_RESET_InLow;
  assign w_tick  = WHEEL_SETPOINT_RAMP_TICK167ms_In;

  assign WHEEL_SETPOINT_RAMP_CMD_READY_Out  = r_live & ~r_pend_v;
  assign WHEEL_SETPOINT_RAMP_TARGETW_OutBus = r_out;
  assign WHEEL_SETPOINT_RAMP_AT_TARGET_Out  = r_at;
  assign WHEEL_SETPOINT_RAMP_TIMEOUT_Out    = r_to;

  assign w_acc = WHEEL_SETPOINT_RAMP_CMD_VALID_In
               & WHEEL_SETPOINT_RAMP_CMD_READY_Out;

  assign w_wd_inc = (r_wd == WD_MAX) ? r_wd : r_wd + 1'b1;

  // An accept on the expiry tick keeps the watchdog quiet.
  assign w_expire = w_tick & ~w_acc & (w_wd_inc == WD_MAX);

  assign w_eff = w_expire ? ZERO_W
               : (r_pend_v ? r_pend : r_tgt);

  wheel_ramp_step u_step (
    .i_out       (r_out),
    .i_eff       (w_eff),
    .i_max_step  (MAX_STEP),
    .o_out_nxt   (w_out_nxt),
    .o_state_nxt (w_st_nxt)
  );

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_live   <= 1'b0;
      r_pend   <= ZERO_W;
      r_pend_v <= 1'b0;
      r_tgt    <= ZERO_W;
      r_out    <= ZERO_W;
      r_wd     <= '0;
      r_at     <= 1'b1;
      r_to     <= 1'b0;
      r_state  <= ST_HOLD;
    end else begin
      r_live <= 1'b1;
      if (w_tick) begin
        r_tgt    <= w_eff;
        r_out    <= w_out_nxt;
        r_state  <= w_st_nxt;
        r_at     <= (w_out_nxt == w_eff);
        r_pend_v <= 1'b0;
        r_wd     <= w_wd_inc;
        if (w_expire)
          r_to <= 1'b1;
      end
      if (w_acc) begin
        r_pend   <= norm_w(WHEEL_SETPOINT_RAMP_CMD_InBus);
        r_pend_v <= 1'b1;
        r_wd     <= '0;
        r_to     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wheel_setpoint_ramp.sv
// Directed and random checks of the setpoint ramp against
// a signed-integer reference model.
module tb_wheel_setpoint_ramp;

  localparam int STEP = 128;
  localparam int WDOG = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic [16:0] cmd = '0;
  logic        valid = 1'b0;
  logic        ready;
  logic [16:0] targetw;
  logic        at_tgt;
  logic        tout;

  int nchk = 0;
  int nerr = 0;

  int m_out, m_tgt, m_pend, m_wd;
  bit m_pv, m_to, m_at, m_live;

  always #5 clk = ~clk;

  wheel_setpoint_ramp dut (
    .WHEEL_SETPOINT_RAMP_CLOCK          (clk),
    .WHEEL_SETPOINT_RAMP_RESET_InLow    (rst_n),
    .WHEEL_SETPOINT_RAMP_TICK167ms_In   (tick),
    .WHEEL_SETPOINT_RAMP_CMD_InBus      (cmd),
    .WHEEL_SETPOINT_RAMP_CMD_VALID_In   (valid),
    .WHEEL_SETPOINT_RAMP_CMD_READY_Out  (ready),
    .WHEEL_SETPOINT_RAMP_TARGETW_OutBus (targetw),
    .WHEEL_SETPOINT_RAMP_AT_TARGET_Out  (at_tgt),
    .WHEEL_SETPOINT_RAMP_TIMEOUT_Out    (tout)
  );

  function automatic int sm2i(input logic [16:0] v);
    int m;
    m = int'(v[15:0]);
    return v[16] ? -m : m;
  endfunction

  function automatic logic [16:0] i2sm(input int x);
    logic [15:0] m;
    if (x == 0) return 17'h00000;
    m = (x < 0) ? 16'(-x) : 16'(x);
    return {(x < 0), m};
  endfunction

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Physical rule: never jump more than STEP, never cross zero
  // in one tick, and pass through zero on a reversal.
  function automatic int step(input int o, input int e);
    if (o != 0 && ((o < 0) != (e < 0))) begin
      if (iabs(o) <= STEP) return 0;
      return (o > 0) ? o - STEP : o + STEP;
    end
    if (iabs(e - o) <= STEP) return e;
    return (e > o) ? o + STEP : o - STEP;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_tgt = 0; m_pend = 0; m_wd = 0;
    m_pv = 0; m_to = 0; m_at = 1; m_live = 0;
  endtask

  task automatic cyc(input bit tk, input bit vl,
                     input logic [16:0] cm);
    bit acc;
    bit exp_t;
    int wdn, eff;
    tick = tk; valid = vl; cmd = cm;
    chk("ready", 32'(ready), 32'(m_live && !m_pv));
    acc = vl && m_live && !m_pv;
    @(posedge clk);
    if (tk) begin
      wdn = acc ? 0 : ((m_wd + 1 > WDOG) ? WDOG : m_wd + 1);
      exp_t = !acc && (wdn == WDOG);
      eff = exp_t ? 0 : (m_pv ? m_pend : m_tgt);
      m_out = step(m_out, eff);
      m_tgt = eff;
      m_at = (m_out == eff);
      m_pv = 0;
      m_wd = wdn;
      if (exp_t) m_to = 1;
    end
    if (acc) begin
      m_pend = sm2i(cm);
      m_pv = 1; m_wd = 0; m_to = 0;
    end
    m_live = 1;
    @(negedge clk);
    tick = 0; valid = 0;
    chk("targetw", 32'(targetw), 32'(i2sm(m_out)));
    chk("at_target", 32'(at_tgt), 32'(m_at));
    chk("timeout", 32'(tout), 32'(m_to));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0);
  endtask

  initial begin
    bit prev_tk;
    bit tk, vl;
    int thr;
    logic [16:0] rc;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_targetw", 32'(targetw), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_at", 32'(at_tgt), 32'h1);
    chk("rst_timeout", 32'(tout), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Ramp up to +2.0
    cyc(0, 1, 17'h00200);
    cyc(1, 0, '0); chk("ramp1", 32'(targetw), 32'h00080);
    cyc(1, 0, '0); chk("ramp2", 32'(targetw), 32'h00100);
    cyc(1, 0, '0); chk("ramp3", 32'(targetw), 32'h00180);
    cyc(1, 0, '0); chk("ramp4", 32'(targetw), 32'h00200);
    chk("ramp_at", 32'(at_tgt), 32'h1);

    // Settle at +1.0 then reverse to -0.75
    cyc(0, 1, 17'h00100);
    cyc(1, 0, '0); idle(1); cyc(1, 0, '0);
    chk("steady", 32'(targetw), 32'h00100);
    cyc(0, 1, 17'h100C0);
    cyc(1, 0, '0); chk("rev1", 32'(targetw), 32'h00080);
    cyc(1, 0, '0); chk("rev2", 32'(targetw), 32'h00000);
    cyc(1, 0, '0); chk("rev3", 32'(targetw), 32'h10080);
    cyc(1, 0, '0); chk("rev4", 32'(targetw), 32'h100C0);

    // Backpressure: A accepted, B stalls until after the tick
    cyc(0, 1, 17'h00040);
    cyc(0, 1, 17'h00020);
    chk("bp_ready", 32'(ready), 32'h0);
    cyc(1, 1, 17'h00020);
    chk("bp_ready2", 32'(ready), 32'h1);
    cyc(0, 1, 17'h00020);
    cyc(1, 0, '0);

    // Watchdog from a fresh +1.0 command
    cyc(0, 1, 17'h00100);
    for (int i = 0; i < 5; i++) cyc(1, 0, '0);
    chk("wd_pre", 32'(tout), 32'h0);
    chk("wd_pre_w", 32'(targetw), 32'h00100);
    cyc(1, 0, '0);
    chk("wd_to", 32'(tout), 32'h1);
    chk("wd_dec1", 32'(targetw), 32'h00080);
    cyc(1, 0, '0);
    chk("wd_dec2", 32'(targetw), 32'h00000);
    cyc(0, 1, 17'h00010);
    chk("wd_clr", 32'(tout), 32'h0);
    cyc(1, 0, '0);

    // Accept on a tick cycle is held for the next tick
    cyc(1, 1, 17'h00050);
    chk("tickacc_hold", 32'(targetw), 32'h00010);
    cyc(1, 0, '0);
    chk("tickacc_use", 32'(targetw), 32'h00050);

    // Negative zero normalises to +0
    cyc(0, 1, 17'h10000);
    cyc(1, 0, '0);
    chk("negzero", 32'(targetw), 32'h00000);

    // Reset mid-ramp with a pending command
    cyc(0, 1, 17'h00300);
    for (int i = 0; i < 3; i++) cyc(1, 0, '0);
    chk("mid_pre", 32'(targetw), 32'h00180);
    cyc(0, 1, 17'h10300);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_w", 32'(targetw), 32'h0);
    chk("mid_rst_rdy", 32'(ready), 32'h0);
    chk("mid_rst_at", 32'(at_tgt), 32'h1);
    chk("mid_rst_to", 32'(tout), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    chk("mid_rdy", 32'(ready), 32'h1);
    cyc(1, 0, '0);
    chk("mid_discard", 32'(targetw), 32'h0);

    // Randomised traffic, with quiet phases for the watchdog
    prev_tk = 0;
    for (int i = 0; i < 1200; i++) begin
      thr = ((i / 150) % 3 == 1) ? 0 : 5;
      tk = !prev_tk && ($urandom_range(0, 3) == 0);
      vl = ($urandom_range(0, 9) < thr);
      rc = {1'($urandom_range(0, 1)),
            16'($urandom_range(0, 16'h0400))};
      if ($urandom_range(0, 15) == 0) rc = 17'h10000;
      cyc(tk, vl, rc);
      prev_tk = tk;
    end

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout watchdog expired");
    $fatal(1, "bench time limit");
  end

endmodule
